// File: rtl/se_lookup_arbiter_pkg.sv
// rtl/se_lookup_arbiter_pkg.sv - shared widths, state encoding and helpers for the lookup arbiter
package se_arb_pkg;

  localparam int SE_MAC_W  = 48;
  localparam int SE_HASH_W = 10;
  localparam int SE_RES_W  = 16;
  localparam int SE_TMR_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } se_state_t;

  // Never returns less than 1 so a 2-requester index is still a legal 1-bit vector.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/se_lookup_arbiter_if.sv
// rtl/se_lookup_arbiter_if.sv - requester, engine and status signals of the lookup arbiter
interface se_lookup_arbiter_if #(
  parameter int NREQ = 2
);
  import se_arb_pkg::*;

  logic [NREQ-1:0]           rq_req;
  logic [NREQ*SE_MAC_W-1:0]  rq_dmac;
  logic [NREQ*SE_MAC_W-1:0]  rq_smac;
  logic [NREQ*SE_HASH_W-1:0] rq_hash;
  logic [NREQ-1:0]           rq_ack;
  logic [NREQ-1:0]           rq_nak;
  logic [SE_RES_W-1:0]       rq_result;
  logic                      se_req;
  logic [SE_MAC_W-1:0]       se_dmac;
  logic [SE_MAC_W-1:0]       se_smac;
  logic [SE_HASH_W-1:0]      se_hash;
  logic                      se_ack;
  logic                      se_nak;
  logic [SE_RES_W-1:0]       se_result;
  logic                      busy;
  logic [SE_TMR_W-1:0]       timeout_cnt;

  modport master (
    input  rq_req, rq_dmac, rq_smac, rq_hash, se_ack, se_nak, se_result,
    output rq_ack, rq_nak, rq_result, se_req, se_dmac, se_smac, se_hash, busy, timeout_cnt
  );

  modport slave (
    output rq_req, rq_dmac, rq_smac, rq_hash, se_ack, se_nak, se_result,
    input  rq_ack, rq_nak, rq_result, se_req, se_dmac, se_smac, se_hash, busy, timeout_cnt
  );

endinterface

// File: rtl/se_lookup_arbiter_rr_pick.sv
// rtl/se_lookup_arbiter_rr_pick.sv - combinational round-robin selector starting after ptr
module rr_pick
  import se_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDXW = clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDXW-1:0] i_ptr,
  output logic            o_gnt_valid,
  output logic [IDXW-1:0] o_gnt_idx
);

  logic [2*NREQ-1:0] w_dbl;
  logic [2*NREQ-1:0] w_masked;
  logic              w_found;

  // Window ptr+1 .. ptr+NREQ of the doubled vector covers every requester once, wrap included.
  always_comb begin
    w_dbl    = {i_req, i_req};
    w_masked = '0;
    for (int i = 0; i < 2*NREQ; i++) begin
      w_masked[i] = w_dbl[i] && (i > int'(i_ptr)) && (i <= int'(i_ptr) + NREQ);
    end
  end

  always_comb begin
    w_found   = 1'b0;
    o_gnt_idx = '0;
    for (int i = 0; i < 2*NREQ; i++) begin
      if (w_masked[i] && !w_found) begin
        w_found   = 1'b1;
        o_gnt_idx = IDXW'(i % NREQ);
      end
    end
  end

  assign o_gnt_valid = |i_req;

endmodule

// File: rtl/se_lookup_arbiter.sv
// rtl/se_lookup_arbiter.sv - round-robin sharing of the MAC search engine with response timeout
module se_lookup_arbiter
  import se_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  se_lookup_arbiter_if.master bus
);

  localparam int                  IDXW     = clog2(NREQ);
  localparam logic [SE_TMR_W-1:0] TMR_LAST = SE_TMR_W'(TIMEOUT - 1);

  se_state_t              r_state;
  se_state_t              w_state_nxt;
  logic [IDXW-1:0]        r_gnt;
  logic [IDXW-1:0]        r_ptr;
  logic [SE_TMR_W-1:0]    r_timer;
  logic [SE_TMR_W-1:0]    r_tcnt;
  logic                   r_se_req;
  logic [SE_MAC_W-1:0]    r_dmac;
  logic [SE_MAC_W-1:0]    r_smac;
  logic [SE_HASH_W-1:0]   r_hash;
  logic [NREQ-1:0]        r_ack;
  logic [NREQ-1:0]        r_nak;
  logic [SE_RES_W-1:0]    r_result;

  logic                   w_pick_valid;
  logic [IDXW-1:0]        w_pick_idx;
  logic [NREQ-1:0]        w_gnt_oh;
  logic                   w_timeout;
  logic                   w_grant;
  logic                   w_resp_ack;
  logic                   w_resp_nak;
  logic                   w_resp_to;
  logic                   w_tick;

  rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_pick (
    .i_req       (bus.rq_req),
    .i_ptr       (r_ptr),
    .o_gnt_valid (w_pick_valid),
    .o_gnt_idx   (w_pick_idx)
  );

  assign w_gnt_oh  = {{(NREQ-1){1'b0}}, 1'b1} << r_gnt;
  assign w_timeout = (r_timer == TMR_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_pick_valid) w_state_nxt = ST_WAIT;
      ST_WAIT: if (bus.se_ack || bus.se_nak || w_timeout) w_state_nxt = ST_HOLD;
      ST_HOLD: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A real ack beats a simultaneous nak; the timeout only fires when the engine stayed silent.
  always_comb begin
    w_grant    = (r_state == ST_IDLE) && w_pick_valid;
    w_resp_ack = (r_state == ST_WAIT) && bus.se_ack;
    w_resp_nak = (r_state == ST_WAIT) && !bus.se_ack && (bus.se_nak || w_timeout);
    w_resp_to  = (r_state == ST_WAIT) && !bus.se_ack && !bus.se_nak && w_timeout;
    w_tick     = (r_state == ST_WAIT) && !bus.se_ack && !bus.se_nak && !w_timeout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt    <= '0;
      r_ptr    <= IDXW'(NREQ - 1);
      r_timer  <= '0;
      r_tcnt   <= '0;
      r_se_req <= 1'b0;
      r_dmac   <= '0;
      r_smac   <= '0;
      r_hash   <= '0;
      r_ack    <= '0;
      r_nak    <= '0;
      r_result <= '0;
    end else begin
      r_ack <= w_resp_ack ? w_gnt_oh : '0;
      r_nak <= w_resp_nak ? w_gnt_oh : '0;
      if (w_grant) begin
        r_gnt    <= w_pick_idx;
        r_ptr    <= w_pick_idx;
        r_dmac   <= bus.rq_dmac[w_pick_idx*SE_MAC_W +: SE_MAC_W];
        r_smac   <= bus.rq_smac[w_pick_idx*SE_MAC_W +: SE_MAC_W];
        r_hash   <= bus.rq_hash[w_pick_idx*SE_HASH_W +: SE_HASH_W];
        r_se_req <= 1'b1;
        r_timer  <= '0;
      end
      if (w_tick) r_timer <= r_timer + SE_TMR_W'(1);
      if (w_resp_ack || w_resp_nak) begin
        r_se_req <= 1'b0;
        r_result <= w_resp_ack ? bus.se_result : '0;
      end
      if (w_resp_to && (r_tcnt != '1)) r_tcnt <= r_tcnt + SE_TMR_W'(1);
    end
  end

  assign bus.rq_ack      = r_ack;
  assign bus.rq_nak      = r_nak;
  assign bus.rq_result   = r_result;
  assign bus.se_req      = r_se_req;
  assign bus.se_dmac     = r_dmac;
  assign bus.se_smac     = r_smac;
  assign bus.se_hash     = r_hash;
  assign bus.busy        = (r_state == ST_WAIT);
  assign bus.timeout_cnt = r_tcnt;

endmodule

// File: tb/tb_se_lookup_arbiter.sv
// tb/tb_se_lookup_arbiter.sv - self-checking bench for se_lookup_arbiter against a grant-order model
module tb_se_lookup_arbiter;
  import se_arb_pkg::*;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 8;

  logic clk;
  logic rst;

  se_lookup_arbiter_if #(.NREQ(NREQ)) bus();

  se_lookup_arbiter #(
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int total;
  int bad;
  int m_ptr;
  logic [15:0] m_tcnt;
  logic [47:0] k_dmac [NREQ];
  logic [47:0] k_smac [NREQ];
  logic [9:0]  k_hash [NREQ];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic rand_keys();
    for (int i = 0; i < NREQ; i++) begin
      k_dmac[i] = {16'($urandom), $urandom};
      k_smac[i] = {16'($urandom), $urandom};
      k_hash[i] = 10'($urandom);
    end
  endtask

  task automatic drive_keys();
    for (int i = 0; i < NREQ; i++) begin
      bus.rq_dmac[i*SE_MAC_W +: SE_MAC_W]   = k_dmac[i];
      bus.rq_smac[i*SE_MAC_W +: SE_MAC_W]   = k_smac[i];
      bus.rq_hash[i*SE_HASH_W +: SE_HASH_W] = k_hash[i];
    end
  endtask

  task automatic wait_se_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.se_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Requester that follows the last grant in rotating order.
  function automatic int exp_grant(input logic [NREQ-1:0] pat);
    for (int k = 1; k <= NREQ; k++) begin
      if (pat[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return 0;
  endfunction

  function automatic logic [NREQ-1:0] oh(input int g);
    logic [NREQ-1:0] v;
    v = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.rq_req = '0; bus.se_ack = 1'b0; bus.se_nak = 1'b0; bus.se_result = '0;
    rand_keys(); drive_keys();
    m_ptr = NREQ - 1; m_tcnt = '0;
    step(); step();
    rst = 1'b0;
    step();
    total++; if ({bus.se_req, bus.busy, bus.rq_ack, bus.rq_nak} !== '0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=0", {bus.se_req, bus.busy, bus.rq_ack, bus.rq_nak}); end
    total++; if (bus.rq_result !== 16'h0 || bus.timeout_cnt !== 16'h0) begin
      bad++; $display("FAIL reset_regs result=%h tcnt=%h exp=0", bus.rq_result, bus.timeout_cnt); end
    total++; if (bus.se_dmac !== 48'h0 || bus.se_smac !== 48'h0 || bus.se_hash !== 10'h0) begin
      bad++; $display("FAIL reset_keys dmac=%h smac=%h hash=%h exp=0", bus.se_dmac, bus.se_smac, bus.se_hash); end
  endtask

  task automatic test_single();
    bit ok;
    int g;
    rand_keys();
    k_dmac[0] = 48'h0011_2233_4455;
    k_hash[0] = 10'h055;
    drive_keys();
    bus.rq_req = 2'b01;
    wait_se_req(ok);
    total++; if (!ok) begin bad++; $display("FAIL single_grant se_req never rose exp=1"); bus.rq_req = '0; return; end
    g = exp_grant(2'b01); m_ptr = g;
    total++; if (bus.se_dmac !== k_dmac[g] || bus.se_hash !== k_hash[g] || bus.se_smac !== k_smac[g]) begin
      bad++; $display("FAIL single_keys dmac=%h hash=%h exp dmac=%h hash=%h", bus.se_dmac, bus.se_hash, k_dmac[g], k_hash[g]); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", bus.busy); end
    step();
    total++; if (bus.rq_ack !== '0 || bus.se_dmac !== k_dmac[g]) begin
      bad++; $display("FAIL single_early ack=%b dmac=%h exp ack=0 dmac=%h", bus.rq_ack, bus.se_dmac, k_dmac[g]); end
    step();
    bus.se_ack = 1'b1; bus.se_result = 16'h000A;
    step();
    bus.se_ack = 1'b0; bus.rq_req = '0;
    total++; if (bus.rq_ack !== oh(g) || bus.rq_nak !== '0 || bus.rq_result !== 16'h000A) begin
      bad++; $display("FAIL single_ack ack=%b nak=%b res=%h exp ack=%b nak=0 res=000a", bus.rq_ack, bus.rq_nak, bus.rq_result, oh(g)); end
    total++; if (bus.se_req !== 1'b0) begin bad++; $display("FAIL single_se_req_drop got=%b exp=0", bus.se_req); end
    step();
    total++; if (bus.rq_ack !== '0) begin bad++; $display("FAIL single_ack_width got=%b exp=0", bus.rq_ack); end
  endtask

  task automatic test_contention();
    logic prev;
    int last_rise, n_grants, n_acks, cur_g;
    logic [15:0] drv_res;
    prev = 1'b0; last_rise = -1; n_grants = 0; n_acks = 0; cur_g = 0; drv_res = '0;
    rand_keys(); drive_keys();
    bus.rq_req = '1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      step();
      if (bus.se_req && !prev) begin
        cur_g = exp_grant('1);
        m_ptr = cur_g;
        n_grants++;
        total++; if (bus.se_dmac !== k_dmac[cur_g]) begin
          bad++; $display("FAIL contention_dmac cyc=%0d got=%h exp=%h", cyc, bus.se_dmac, k_dmac[cur_g]); end
        if (last_rise >= 0) begin
          total++; if (cyc - last_rise != 3) begin
            bad++; $display("FAIL contention_spacing got=%0d exp=3", cyc - last_rise); end
        end
        last_rise = cyc;
      end
      if (bus.rq_ack !== '0) begin
        n_acks++;
        total++; if (bus.rq_ack !== oh(cur_g) || bus.rq_result !== drv_res) begin
          bad++; $display("FAIL contention_ack ack=%b res=%h exp ack=%b res=%h", bus.rq_ack, bus.rq_result, oh(cur_g), drv_res); end
      end
      prev = bus.se_req;
      bus.se_ack = bus.se_req;
      drv_res = 16'($urandom);
      bus.se_result = drv_res;
    end
    bus.rq_req = '0; bus.se_ack = 1'b0;
    step();
    total++; if (n_grants != 10 || n_acks != 10) begin
      bad++; $display("FAIL contention_count grants=%0d acks=%0d exp=10/10", n_grants, n_acks); end
  endtask

  task automatic test_nak_priority();
    bit ok;
    int g;
    logic [15:0] r;
    rand_keys(); drive_keys();
    bus.rq_req = 2'b10;
    wait_se_req(ok);
    total++; if (!ok) begin bad++; $display("FAIL nak_grant se_req never rose exp=1"); bus.rq_req = '0; return; end
    g = exp_grant(2'b10); m_ptr = g;
    bus.se_nak = 1'b1; bus.se_result = 16'hBEEF;
    step();
    bus.se_nak = 1'b0;
    total++; if (bus.rq_nak !== oh(g) || bus.rq_ack !== '0 || bus.rq_result !== 16'h0 || bus.se_req !== 1'b0) begin
      bad++; $display("FAIL nak_pulse nak=%b ack=%b res=%h se_req=%b exp nak=%b ack=0 res=0 se_req=0",
                      bus.rq_nak, bus.rq_ack, bus.rq_result, bus.se_req, oh(g)); end
    bus.rq_req = '0;
    step();
    bus.rq_req = 2'b10;
    wait_se_req(ok);
    total++; if (!ok) begin bad++; $display("FAIL prio_grant se_req never rose exp=1"); bus.rq_req = '0; return; end
    g = exp_grant(2'b10); m_ptr = g;
    r = 16'($urandom) | 16'h1;
    bus.se_ack = 1'b1; bus.se_nak = 1'b1; bus.se_result = r;
    step();
    bus.se_ack = 1'b0; bus.se_nak = 1'b0; bus.rq_req = '0;
    total++; if (bus.rq_ack !== oh(g) || bus.rq_nak !== '0 || bus.rq_result !== r) begin
      bad++; $display("FAIL prio_ack ack=%b nak=%b res=%h exp ack=%b nak=0 res=%h", bus.rq_ack, bus.rq_nak, bus.rq_result, oh(g), r); end
    step();
  endtask

  task automatic test_timeout();
    bit ok;
    int g;
    rand_keys(); drive_keys();
    bus.rq_req = 2'b01;
    wait_se_req(ok);
    total++; if (!ok) begin bad++; $display("FAIL timeout_grant se_req never rose exp=1"); bus.rq_req = '0; return; end
    g = exp_grant(2'b01); m_ptr = g;
    repeat (TIMEOUT - 1) step();
    total++; if (bus.rq_nak !== '0 || bus.se_req !== 1'b1) begin
      bad++; $display("FAIL timeout_early nak=%b se_req=%b exp nak=0 se_req=1", bus.rq_nak, bus.se_req); end
    step();
    m_tcnt = m_tcnt + 16'd1;
    total++; if (bus.rq_nak !== oh(g) || bus.se_req !== 1'b0 || bus.timeout_cnt !== m_tcnt) begin
      bad++; $display("FAIL timeout_nak nak=%b se_req=%b tcnt=%0d exp nak=%b se_req=0 tcnt=%0d",
                      bus.rq_nak, bus.se_req, bus.timeout_cnt, oh(g), m_tcnt); end
    bus.se_ack = 1'b1; bus.rq_req = '0;
    step();
    total++; if (bus.rq_ack !== '0) begin bad++; $display("FAIL late_ack_hold got=%b exp=0", bus.rq_ack); end
    step();
    bus.se_ack = 1'b0;
    total++; if (bus.rq_ack !== '0 || bus.rq_nak !== '0 || bus.se_req !== 1'b0) begin
      bad++; $display("FAIL late_ack_idle ack=%b nak=%b se_req=%b exp=0", bus.rq_ack, bus.rq_nak, bus.se_req); end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    int g;
    rand_keys(); drive_keys();
    bus.rq_req = 2'b01;
    wait_se_req(ok);
    total++; if (!ok) begin bad++; $display("FAIL rstwait_grant se_req never rose exp=1"); bus.rq_req = '0; return; end
    m_ptr = exp_grant(2'b01);
    step();
    #2 rst = 1'b1;
    #1;
    total++; if ({bus.se_req, bus.busy, bus.rq_ack, bus.rq_nak} !== '0 || bus.timeout_cnt !== 16'h0) begin
      bad++; $display("FAIL rstwait_async ctrl=%b tcnt=%h exp=0", {bus.se_req, bus.busy, bus.rq_ack, bus.rq_nak}, bus.timeout_cnt); end
    bus.rq_req = 2'b10;
    m_ptr = NREQ - 1; m_tcnt = '0;
    step();
    rst = 1'b0;
    wait_se_req(ok);
    total++; if (!ok) begin bad++; $display("FAIL rstwait_regrant se_req never rose exp=1"); bus.rq_req = '0; return; end
    g = exp_grant(2'b10); m_ptr = g;
    total++; if (bus.se_dmac !== k_dmac[g] || bus.se_hash !== k_hash[g]) begin
      bad++; $display("FAIL rstwait_keys dmac=%h exp=%h", bus.se_dmac, k_dmac[g]); end
    bus.se_ack = 1'b1; bus.se_result = 16'h5A5A;
    step();
    bus.se_ack = 1'b0; bus.rq_req = '0;
    total++; if (bus.rq_ack !== oh(g)) begin bad++; $display("FAIL rstwait_ack got=%b exp=%b", bus.rq_ack, oh(g)); end
    step();
  endtask

  task automatic test_random();
    bit ok;
    int g, kind, lat;
    logic [NREQ-1:0] pat;
    logic [47:0] cap_d, cap_s;
    logic [9:0] cap_h;
    logic [15:0] r;
    for (int it = 0; it < 30; it++) begin
      pat = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      rand_keys(); drive_keys();
      bus.rq_req = pat;
      wait_se_req(ok);
      total++; if (!ok) begin bad++; $display("FAIL rand_grant it=%0d se_req never rose", it); bus.rq_req = '0; return; end
      g = exp_grant(pat); m_ptr = g;
      cap_d = k_dmac[g]; cap_s = k_smac[g]; cap_h = k_hash[g];
      total++; if (bus.se_dmac !== cap_d || bus.se_smac !== cap_s || bus.se_hash !== cap_h) begin
        bad++; $display("FAIL rand_keys it=%0d dmac=%h exp=%h (grant %0d)", it, bus.se_dmac, cap_d, g); end
      rand_keys(); drive_keys();
      kind = $urandom_range(0, 3);
      lat  = (kind == 3) ? TIMEOUT - 1 : $urandom_range(0, 4);
      r    = 16'($urandom);
      repeat (lat) step();
      bus.se_result = r;
      bus.se_ack = (kind == 0 || kind == 2);
      bus.se_nak = (kind == 1 || kind == 2);
      step();
      bus.se_ack = 1'b0; bus.se_nak = 1'b0;
      if (kind == 3 && m_tcnt != 16'hFFFF) m_tcnt = m_tcnt + 16'd1;
      total++; if (bus.rq_ack !== ((kind == 0 || kind == 2) ? oh(g) : '0) ||
                   bus.rq_nak !== ((kind == 1 || kind == 3) ? oh(g) : '0)) begin
        bad++; $display("FAIL rand_resp it=%0d kind=%0d ack=%b nak=%b grant=%0d", it, kind, bus.rq_ack, bus.rq_nak, g); end
      total++; if (bus.rq_result !== ((kind == 0 || kind == 2) ? r : 16'h0) || bus.se_req !== 1'b0) begin
        bad++; $display("FAIL rand_result it=%0d got=%h se_req=%b exp=%h se_req=0", it, bus.rq_result, bus.se_req,
                        (kind == 0 || kind == 2) ? r : 16'h0); end
      total++; if (bus.se_dmac !== cap_d || bus.timeout_cnt !== m_tcnt) begin
        bad++; $display("FAIL rand_hold it=%0d dmac=%h tcnt=%0d exp dmac=%h tcnt=%0d", it, bus.se_dmac, bus.timeout_cnt, cap_d, m_tcnt); end
      bus.rq_req = '0;
      step();
      total++; if (bus.rq_ack !== '0 || bus.rq_nak !== '0) begin
        bad++; $display("FAIL rand_pulse it=%0d ack=%b nak=%b exp=0", it, bus.rq_ack, bus.rq_nak); end
    end
  endtask

  task automatic test_saturation();
    bit ok;
    int g;
    force dut.r_tcnt = 16'hFFFE;
    #1;
    release dut.r_tcnt;
    m_tcnt = 16'hFFFE;
    for (int t = 0; t < 2; t++) begin
      bus.rq_req = 2'b01;
      wait_se_req(ok);
      total++; if (!ok) begin bad++; $display("FAIL sat_grant se_req never rose exp=1"); bus.rq_req = '0; return; end
      g = exp_grant(2'b01); m_ptr = g;
      repeat (TIMEOUT) step();
      if (m_tcnt != 16'hFFFF) m_tcnt = m_tcnt + 16'd1;
      total++; if (bus.timeout_cnt !== m_tcnt || bus.rq_nak !== oh(g)) begin
        bad++; $display("FAIL sat_count tcnt=%h nak=%b exp tcnt=%h nak=%b", bus.timeout_cnt, bus.rq_nak, m_tcnt, oh(g)); end
      bus.rq_req = '0;
      step();
    end
    bus.se_ack = 1'b1; bus.se_result = 16'h1234;
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (bus.rq_ack !== '0 || bus.se_req !== 1'b0 || bus.busy !== 1'b0) begin
        bad++; $display("FAIL stale_ack ack=%b se_req=%b busy=%b exp=0", bus.rq_ack, bus.se_req, bus.busy); end
    end
    bus.se_ack = 1'b0;
    total++; if (bus.timeout_cnt !== 16'hFFFF) begin
      bad++; $display("FAIL sat_hold got=%h exp=ffff", bus.timeout_cnt); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_contention();
    test_nak_priority();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
